// File: rtl/alu_seq_ctrl.sv
// Execute-stage sequencer: owns ACC, MQ and the C/V/Z flags, steers the shared ALU,
// and runs unsigned MUL as an N-pass shift-add loop through that same ALU.
module alu_seq_ctrl #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [2:0]   op,
    input  logic [N-1:0] operand,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] acc,
    output logic [N-1:0] mq,
    output logic         flag_c,
    output logic         flag_v,
    output logic         flag_z,
    output logic [N-1:0] alu_in0,
    output logic [N-1:0] alu_in1,
    output logic         alu_cin,
    output logic [2:0]   alu_ctrl,
    input  logic [N-1:0] alu_out,
    input  logic         alu_cout,
    input  logic         alu_v,
    input  logic         alu_z
);

    localparam int CW = $clog2(N + 1);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_NOT  = 3'b100;
    localparam logic [2:0] OP_LOAD = 3'b101;
    localparam logic [2:0] OP_MUL  = 3'b110;
    localparam logic [2:0] OP_ADC  = 3'b111;

    localparam logic [2:0] CTRL_ADD = 3'b000;
    localparam logic [2:0] CTRL_SUB = 3'b001;
    localparam logic [2:0] CTRL_OR  = 3'b010;
    localparam logic [2:0] CTRL_AND = 3'b100;
    localparam logic [2:0] CTRL_NOT = 3'b110;

    typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_t;

    state_t        state, next_state;
    logic [N-1:0]  opnd_r;
    logic [2:0]    op_r;
    logic [CW-1:0] cnt;

    logic          accept;
    logic          last_iter;
    logic [N:0]    mul_sum;
    logic [N-1:0]  mul_acc;
    logic [N-1:0]  mul_mq;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    assign accept    = (state == IDLE) && start;
    assign last_iter = (cnt == CW'(N - 1));

    always_comb begin
        next_state = state;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) next_state = (op == OP_MUL) ? MUL : EXEC;
            end
            EXEC: next_state = DONE;
            MUL:  if (last_iter) next_state = DONE;
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // IDLE/DONE park the ALU on ACC+0 so its inputs stay quiet between instructions.
    always_comb begin
        alu_in0  = acc;
        alu_in1  = '0;
        alu_ctrl = CTRL_ADD;
        alu_cin  = 1'b0;
        if (state == MUL) begin
            alu_in1 = opnd_r;
        end else if (state == EXEC) begin
            case (op_r)
                OP_ADD: alu_in1 = opnd_r;
                OP_ADC: begin
                    alu_in1 = opnd_r;
                    alu_cin = flag_c;
                end
                OP_SUB: begin
                    alu_in1  = opnd_r;
                    alu_ctrl = CTRL_SUB;
                    alu_cin  = 1'b1;
                end
                OP_AND: begin
                    alu_in1  = opnd_r;
                    alu_ctrl = CTRL_AND;
                end
                OP_OR: begin
                    alu_in1  = opnd_r;
                    alu_ctrl = CTRL_OR;
                end
                OP_NOT:  alu_ctrl = CTRL_NOT;
                OP_LOAD: begin
                    alu_in0  = opnd_r;
                    alu_ctrl = CTRL_OR;
                end
                default: ;
            endcase
        end
    end

    // One shift-add step: add the multiplicand only when the current multiplier bit is set.
    assign mul_sum = mq[0] ? {alu_cout, alu_out} : {1'b0, acc};
    assign mul_acc = mul_sum[N:1];
    assign mul_mq  = {mul_sum[0], mq[N-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            mq     <= '0;
            opnd_r <= '0;
            op_r   <= '0;
            cnt    <= '0;
            flag_c <= 1'b0;
            flag_v <= 1'b0;
            flag_z <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    op_r   <= op;
                    opnd_r <= operand;
                    if (op == OP_MUL) begin
                        mq  <= acc;
                        acc <= '0;
                        cnt <= '0;
                    end
                end
                EXEC: begin
                    acc    <= alu_out;
                    flag_z <= alu_z;
                    if (op_r == OP_ADD || op_r == OP_ADC || op_r == OP_SUB) begin
                        flag_c <= alu_cout;
                        flag_v <= alu_v;
                    end else begin
                        flag_v <= 1'b0;
                    end
                end
                MUL: begin
                    acc <= mul_acc;
                    mq  <= mul_mq;
                    cnt <= cnt + 1'b1;
                    if (last_iter) begin
                        flag_c <= 1'b0;
                        flag_v <= (mul_acc != '0);
                        flag_z <= (mul_acc == '0) && (mul_mq == '0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl; the shared ALU is modelled here and
// every expected value below is hand-computed.
module tb_alu_seq_ctrl;

    localparam int N = 8;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_NOT  = 3'b100;
    localparam logic [2:0] OP_LOAD = 3'b101;
    localparam logic [2:0] OP_MUL  = 3'b110;
    localparam logic [2:0] OP_ADC  = 3'b111;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [2:0]   op;
    logic [N-1:0] operand;
    logic         busy, done;
    logic [N-1:0] acc, mq;
    logic         flag_c, flag_v, flag_z;
    logic [N-1:0] alu_in0, alu_in1;
    logic         alu_cin;
    logic [2:0]   alu_ctrl;
    logic [N-1:0] alu_out;
    logic         alu_cout, alu_v, alu_z;

    int checks = 0;
    int passes = 0;

    alu_seq_ctrl #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .operand(operand),
        .busy(busy), .done(done), .acc(acc), .mq(mq),
        .flag_c(flag_c), .flag_v(flag_v), .flag_z(flag_z),
        .alu_in0(alu_in0), .alu_in1(alu_in1), .alu_cin(alu_cin), .alu_ctrl(alu_ctrl),
        .alu_out(alu_out), .alu_cout(alu_cout), .alu_v(alu_v), .alu_z(alu_z)
    );

    always #5 clk = ~clk;

    // Reference ALU that the sequencer drives.
    always_comb begin
        logic [N:0] t;
        t        = '0;
        alu_out  = '0;
        alu_cout = 1'b0;
        alu_v    = 1'b0;
        case (alu_ctrl)
            3'b000: begin
                t        = {1'b0, alu_in0} + {1'b0, alu_in1} + {{N{1'b0}}, alu_cin};
                alu_out  = t[N-1:0];
                alu_cout = t[N];
                alu_v    = (alu_in0[N-1] == alu_in1[N-1]) && (alu_out[N-1] != alu_in0[N-1]);
            end
            3'b001: begin
                t        = {1'b0, alu_in0} + {1'b0, ~alu_in1} + {{N{1'b0}}, alu_cin};
                alu_out  = t[N-1:0];
                alu_cout = t[N];
                alu_v    = (alu_in0[N-1] != alu_in1[N-1]) && (alu_out[N-1] != alu_in0[N-1]);
            end
            3'b010:  alu_out = alu_in0 | alu_in1;
            3'b100:  alu_out = alu_in0 & alu_in1;
            3'b110:  alu_out = ~alu_in0;
            default: alu_out = '0;
        endcase
        alu_z = (alu_out == '0);
    end

    task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    endtask

    // Issue one instruction once the block is idle; returns with done visible.
    task automatic applyStimulus(input logic [2:0] o, input logic [N-1:0] d,
                                 input logic [2:0] exp_ctrl, input logic exp_cin, input int exp_lat);
        int cycles;
        int waits;
        waits = 0;
        @(negedge clk);
        while (busy && waits < 30) begin
            @(negedge clk);
            waits++;
        end
        start   = 1'b1;
        op      = o;
        operand = d;
        @(posedge clk);
        #1;
        start = 1'b0;
        cycles = 1;
        checkOutput("busy_after_accept", 16'(busy), 16'd1);
        checkOutput("alu_ctrl", 16'(alu_ctrl), 16'(exp_ctrl));
        checkOutput("alu_cin", 16'(alu_cin), 16'(exp_cin));
        while (!done && cycles < 30) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        checkOutput("done_seen", 16'(done), 16'd1);
        checkOutput("latency", 16'(cycles), 16'(exp_lat));
    endtask

    task automatic checkState(input string tag, input logic [N-1:0] e_acc, input logic [N-1:0] e_mq,
                              input logic e_c, input logic e_v, input logic e_z);
        checkOutput({tag, "_acc"}, 16'(acc), 16'(e_acc));
        checkOutput({tag, "_mq"}, 16'(mq), 16'(e_mq));
        checkOutput({tag, "_cvz"}, 16'({flag_c, flag_v, flag_z}), 16'({e_c, e_v, e_z}));
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        op      = '0;
        operand = '0;
        #2;
        checkState("reset", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        checkOutput("reset_busy_done", 16'({busy, done}), 16'd0);
        checkOutput("reset_alu", 16'({alu_in0, alu_ctrl, alu_cin}), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Signed overflow on ADD
        applyStimulus(OP_LOAD, 8'h7F, 3'b010, 1'b0, 2);
        checkState("load7f", 8'h7F, 8'h00, 1'b0, 1'b0, 1'b0);
        applyStimulus(OP_ADD, 8'h01, 3'b000, 1'b0, 2);
        checkState("add_ovf", 8'h80, 8'h00, 1'b0, 1'b1, 1'b0);

        // SUB to zero, then ADC consumes the no-borrow carry
        applyStimulus(OP_LOAD, 8'h05, 3'b010, 1'b0, 2);
        applyStimulus(OP_SUB, 8'h05, 3'b001, 1'b1, 2);
        checkState("sub_zero", 8'h00, 8'h00, 1'b1, 1'b0, 1'b1);
        applyStimulus(OP_ADC, 8'h00, 3'b000, 1'b1, 2);
        checkState("adc", 8'h01, 8'h00, 1'b0, 1'b0, 1'b0);

        // Logic ops keep C (set to 1 first by F0-00)
        applyStimulus(OP_LOAD, 8'hF0, 3'b010, 1'b0, 2);
        applyStimulus(OP_SUB, 8'h00, 3'b001, 1'b1, 2);
        checkState("sub_c1", 8'hF0, 8'h00, 1'b1, 1'b0, 1'b0);
        applyStimulus(OP_AND, 8'h3C, 3'b100, 1'b0, 2);
        checkState("and", 8'h30, 8'h00, 1'b1, 1'b0, 1'b0);
        applyStimulus(OP_OR, 8'h0F, 3'b010, 1'b0, 2);
        checkState("or", 8'h3F, 8'h00, 1'b1, 1'b0, 1'b0);
        applyStimulus(OP_NOT, 8'h00, 3'b110, 1'b0, 2);
        checkState("not", 8'hC0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Multiply: 0x0F*0x11=0x00FF, 0xFF*0xFF=0xFE01, 0x00*0x5A=0
        applyStimulus(OP_LOAD, 8'h0F, 3'b010, 1'b0, 2);
        applyStimulus(OP_MUL, 8'h11, 3'b000, 1'b0, 9);
        checkState("mul_0f_11", 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0);
        applyStimulus(OP_LOAD, 8'hFF, 3'b010, 1'b0, 2);
        checkState("load_keeps_mq", 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0);
        applyStimulus(OP_MUL, 8'hFF, 3'b000, 1'b0, 9);
        checkState("mul_ff_ff", 8'hFE, 8'h01, 1'b0, 1'b1, 1'b0);
        applyStimulus(OP_LOAD, 8'h00, 3'b010, 1'b0, 2);
        applyStimulus(OP_MUL, 8'h5A, 3'b000, 1'b0, 9);
        checkState("mul_zero", 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);

        // start held high across a whole instruction: the second op waits for IDLE
        @(negedge clk);
        while (busy) @(negedge clk);
        start   = 1'b1;
        op      = OP_LOAD;
        operand = 8'h10;
        @(negedge clk);
        op      = OP_ADD;
        operand = 8'h01;
        @(posedge clk); #1;
        checkOutput("hold_done1", 16'({done, acc}), 16'({1'b1, 8'h10}));
        @(posedge clk); #1;
        checkOutput("hold_idle_gap", 16'({busy, acc}), 16'({1'b0, 8'h10}));
        @(posedge clk); #1;
        checkOutput("hold_accept2", 16'(busy), 16'd1);
        start = 1'b0;
        @(posedge clk); #1;
        checkOutput("hold_done2", 16'({done, acc}), 16'({1'b1, 8'h11}));

        // Async reset in the middle of a multiply
        applyStimulus(OP_LOAD, 8'h03, 3'b010, 1'b0, 2);
        @(negedge clk);
        while (busy) @(negedge clk);
        start   = 1'b1;
        op      = OP_MUL;
        operand = 8'h05;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkState("midmul_reset", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        checkOutput("midmul_busy_done", 16'({busy, done}), 16'd0);
        checkOutput("midmul_alu", 16'({alu_in0, alu_in1, alu_ctrl, alu_cin}), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(OP_LOAD, 8'h02, 3'b010, 1'b0, 2);
        applyStimulus(OP_ADD, 8'h03, 3'b000, 1'b0, 2);
        checkState("after_reset", 8'h05, 8'h00, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
